// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the fetch PC and issues one-at-a-time word requests to instruction memory.
// Returned words go into a small prefetch FIFO for decode; taken branches flush it and redirect fetch.
module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_read,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  entry_t           entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_next;
  logic [31:0]      target;
  logic [31:0]      addr_next;
  logic             req_next;
  logic             push;
  logic             pop;
  logic [1:0]       unused_target_bits;
  state_t           state;
  state_t           state_next;

  assign target             = {branch_target[31:2], 2'b00};
  assign unused_target_bits = branch_target[1:0];

  // A flush voids both the acked word and any pop in the same cycle.
  assign push        = (state == REQ) && imem_ack && !branch_taken;
  assign pop         = instr_valid && instr_ready && !branch_taken;
  assign instr_valid = (count != '0);
  assign instr_out   = entries[rd_ptr].instr;
  assign pc_out      = entries[rd_ptr].addr;
  assign pc_read     = pc_out + 32'd8;

  always_comb begin
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    if (branch_taken) count_next = '0;
  end

  // In DROP the fetch PC doubles as the stored redirect target.
  always_comb begin
    fetch_pc_next = fetch_pc;
    if (branch_taken)  fetch_pc_next = target;
    else if (push)     fetch_pc_next = fetch_pc + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (branch_taken || (count_next < FULL)) state_next = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (!branch_taken && (count_next >= FULL)) state_next = IDLE;
        end else if (branch_taken) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem_ack) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // A request already on the bus keeps its address until it is acked.
  always_comb begin
    req_next  = (state_next != IDLE);
    addr_next = (state_next == DROP) ? imem_addr : fetch_pc_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      imem_req  <= req_next;
      imem_addr <= addr_next;
      fetch_pc  <= fetch_pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      count <= count_next;
      if (branch_taken) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          entries[wr_ptr] <= {imem_data, imem_addr};
          wr_ptr          <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: directed scenarios followed by random traffic, checked
// by a scoreboard of expected {instr, addr} entries and a monitor that compares at the queue head.
module tb_instruction_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_read;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;

  exp_t        sb[$];
  logic [31:0] exp_pc;
  logic        drop_pend;
  bit          mon_en;
  bit          idle_prev;
  logic        last_req;
  logic [31:0] last_addr;
  int          checks;
  int          failures;

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .pc_read      (pc_read),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  // One cycle of stimulus: inputs applied after negedge, model committed after the posedge.
  task automatic drive_cycle(input logic a, input logic r, input logic b, input logic [31:0] t);
    logic [31:0] d;
    logic        req_s;
    @(negedge clk);
    #1;
    d             = $urandom;
    imem_ack      = a;
    instr_ready   = r;
    branch_taken  = b;
    branch_target = t;
    imem_data     = d;
    req_s         = imem_req;
    last_req      = imem_req;
    last_addr     = imem_addr;
    if (req_s && !drop_pend) chk("imem_addr", imem_addr, exp_pc);
    @(posedge clk);
    #1;
    if (b) begin
      sb.delete();
      exp_pc    = {t[31:2], 2'b00};
      drop_pend = req_s && !a;
    end else if (req_s && a) begin
      if (drop_pend) begin
        drop_pend = 1'b0;
      end else begin
        sb.push_back({d, exp_pc});
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_pc    = RPC;
    drop_pend = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_imem_req"},    32'(imem_req),    32'd0);
    chk({tag, "_imem_addr"},   imem_addr,        RPC);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr_out"},   instr_out,        32'd0);
    chk({tag, "_pc_out"},      pc_out,           32'd0);
    chk({tag, "_pc_read"},     pc_read,          32'd8);
  endtask

  // Monitor: samples just before each rising edge and checks the head against the scoreboard.
  initial begin
    exp_t h;
    idle_prev = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (mon_en) begin
        chk("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
        if (instr_valid && (sb.size() != 0)) begin
          h = sb[0];
          chk("instr_out", instr_out, h.instr);
          chk("pc_out",    pc_out,    h.addr);
          chk("pc_read",   pc_read,   h.addr + 32'd8);
          if (instr_ready && !branch_taken) void'(sb.pop_front());
        end
        if (imem_req)  chk("req_with_room", 32'(sb.size() < DEPTH), 32'd1);
        if (idle_prev) chk("req_restart",   32'(imem_req),          32'd1);
        idle_prev = !imem_req && (sb.size() < DEPTH);
      end else begin
        idle_prev = 1'b0;
      end
    end
  end

  initial begin
    checks        = 0;
    failures      = 0;
    mon_en        = 1'b0;
    reset         = 1'b1;
    imem_ack      = 1'b0;
    imem_data     = '0;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    last_req      = 1'b0;
    last_addr     = '0;
    model_reset();

    @(negedge clk);
    #4;
    chk_reset_values("rst");
    @(negedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // First fetch after reset: four back-to-back acks fill the queue, then requests stop.
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      chk("first_req", 32'(last_req), 32'(i < 4));
      if (i < 4) chk("first_addr", last_addr, RPC + 32'(4 * i));
    end
    chk("first_valid",   32'(instr_valid), 32'd1);
    chk("first_pc_out",  pc_out,  32'h0000_0100);
    chk("first_pc_read", pc_read, 32'h0000_0108);

    // Pop one, then push and pop together with three entries held.
    drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("pushpop_pc_out", pc_out, 32'h0000_0108);
    chk("pushpop_valid",  32'(instr_valid), 32'd1);

    // Flush without ack: address held until the late ack, which is dropped.
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_2002);
    chk("drop_addr_held", imem_addr, 32'h0000_0114);
    chk("drop_req",       32'(imem_req), 32'd1);
    chk("drop_valid",     32'(instr_valid), 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("drop_addr_wait", imem_addr, 32'h0000_0114);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("drop_redirect",  imem_addr, 32'h0000_2000);
    chk("drop_valid_end", 32'(instr_valid), 32'd0);

    // Flush coincident with ack and pop.
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("pre_flush_pc", pc_out, 32'h0000_2000);
    drive_cycle(1'b1, 1'b1, 1'b1, 32'h0000_3000);
    chk("flush_ack_valid", 32'(instr_valid), 32'd0);
    chk("flush_ack_addr",  imem_addr, 32'h0000_3000);

    // PC wrap, with the low target bits ignored.
    drive_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("wrap_pc0",   pc_out,  32'hFFFF_FFFC);
    chk("wrap_read0", pc_read, 32'h0000_0004);
    drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_pc1",   pc_out,  32'h0000_0000);
    chk("wrap_read1", pc_read, 32'h0000_0008);

    // Asynchronous reset pulse between edges while an ack is pending.
    @(negedge clk);
    #1;
    mon_en       = 1'b0;
    imem_ack     = 1'b1;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    chk("pre_reset_req", 32'(imem_req), 32'd1);
    #1 reset = 1'b1;
    #1 chk_reset_values("async");
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("post_reset_valid", 32'(instr_valid), 32'd0);
    chk("post_reset_req",   32'(imem_req),    32'd1);
    chk("post_reset_addr",  imem_addr,        RPC);
    mon_en = 1'b1;

    // Random traffic.
    repeat (3000) begin
      drive_cycle(1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 99) < 55),
                  1'($urandom_range(0, 99) < 5),
                  $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Fetch stage of the ARM datapath. It owns the fetch PC and issues word requests to instruction memory over a request/acknowledge handshake. Returned words are buffered in a small prefetch FIFO that feeds decode, whose `instr_out` drives the instruction input of the shifter/sign-extender. Taken branches, whose target comes from the sign-extended, shifted 24-bit offset, flush the queue and redirect fetch.

## Interface
- `DEPTH`, 4: queue entries, power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `imem_req` out 1: memory request; registered.
- `imem_addr` out 32: word address of the request; registered, bits [1:0] always 0.
- `imem_ack` in 1: memory returns `imem_data` for the pending request this cycle.
- `imem_data` in 32: instruction word, sampled only when `imem_req && imem_ack`.
- `instr_out` out 32: queue head instruction.
- `pc_out` out 32: address of the head instruction.
- `pc_read` out 32: `pc_out + 8` (ARM r15 read value).
- `instr_valid` out 1: head entry valid (`count != 0`).
- `instr_ready` in 1: decode accepts the head this cycle.
- `branch_taken` in 1: flush and redirect.
- `branch_target` in 32: redirect address; bits [1:0] ignored (treated as 0).

## Operation
- Storage: `DEPTH` entries of {instr[31:0], addr[31:0]}, with read and write pointers wrapping modulo `DEPTH` and a `count` ranging from 0 to `DEPTH`.
- Push occurs when `imem_req && imem_ack` in state REQ and no flush is active. Pop occurs when `instr_valid && instr_ready` and no flush is active. When push and pop happen in the same cycle, `count` is unchanged.
- `fetch_pc` is a 32-bit register that wraps modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0.
- FSM states:
  - **IDLE**: `imem_req`=0. Moves to REQ next cycle if `count_next < DEPTH` or on flush.
  - **REQ**: `imem_req`=1, `imem_addr`=`fetch_pc`.
    - On ack without flush: push, `fetch_pc += 4`. Stay in REQ (back-to-back) if `count_next < DEPTH`, else go to IDLE.
    - On ack with flush: discard the data, set `fetch_pc = target`, stay in REQ.
    - On flush without ack: go to DROP.
    - Without ack, `imem_addr` holds stable.
  - **DROP**: `imem_req` stays 1 and `imem_addr` holds the old address; a started request is never abandoned. On ack, discard the data and go to REQ at the stored target. A second flush while in DROP overwrites the stored target.
- Only one request is ever outstanding. A request is issued only when `count < DEPTH`, so every ack always has a free slot.
- Flush (`branch_taken`=1):
  - Queue empties next cycle.
  - `instr_valid`=0 next cycle.
  - Any pop in the same cycle is void.
  - `fetch_pc` (or the stored target in DROP) becomes `{branch_target[31:2], 2'b00}`.
- Reset mid-operation: all state is cleared immediately and any pending ack is ignored. The memory must tolerate a dropped request.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `fetch_pc`=`RESET_PC`, `count`=0, `instr_valid`=0, `instr_out`=0, `pc_out`=0, `pc_read`=8, FSM state=IDLE.
- First `imem_req`=1 appears on the first rising edge after `reset` deasserts.
- Ack-to-valid latency: a word acked at edge N appears on `instr_out` with `instr_valid`=1 after edge N, provided the queue was empty.
- Sustained throughput is 1 instruction per cycle with a zero-wait memory (ack in the same cycle as `imem_req`) and `instr_ready`=1.
- Branch penalty:
  - `branch_taken` at edge N → `imem_addr`=target after edge N (IDLE/REQ).
  - In DROP, `imem_addr`=target the edge after the dropped ack.
- `instr_out`, `pc_out`, and `pc_read` are stable whenever `instr_valid`=1 and `instr_ready`=0.

## Test plan
- **Reset/first fetch**: `RESET_PC`=0x100, ack every cycle, `instr_ready`=0 → `imem_addr` steps through 0x100, 0x104, 0x108, 0x10C. `imem_req` drops after the 4th ack. `instr_valid`=1, `pc_out`=0x100, `pc_read`=0x108.
- **Full with simultaneous push/pop**: queue holds 3 entries, ack and `instr_ready` high together → `count` stays 3 and the head advances by 4.
- **Flush in REQ without ack**: `branch_taken`=1, target 0x2002, while ack is low → state goes to DROP with `imem_addr` held. After the late ack, the data is discarded, `imem_addr`=0x2000, and `instr_valid`=0 throughout.
- **Flush coincident with ack and pop**: `branch_taken` + `imem_ack` + `instr_ready` in one cycle → acked word not queued, `count`=0 next cycle, `imem_addr`=target.
- **PC wrap**: `branch_target`=0xFFFF_FFFC, two acks → `pc_out` sequence is 0xFFFF_FFFC then 0x0. `pc_read` of the first entry = 0x4.
- **Async reset mid-REQ**: `reset` pulses between edges with ack pending → outputs reach reset values before the next edge, and the ack is ignored.
